sys_cmd_master: RTL and testbench

- Host-side initiator for the 4-frame UART command protocol that the system controller parses. Converts one parallel command request into a byte stream for a UART transmitter, then collects the reply bytes from a UART receiver.
- Sits on the far end of the serial link, in an FPGA test harness or companion chip. Drives a UART TX byte interface and consumes a UART RX byte interface.

---
 rtl/sys_cmd_pkg.sv | 53 +++++
 rtl/sys_cmd_master_if.sv | 43 ++++
 rtl/sys_cmd_timeout.sv | 29 ++
 rtl/sys_cmd_master.sv | 161 ++++++++++++++++
 tb/tb_sys_cmd_master.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_cmd_pkg.sv
// Shared definitions for the host-side command initiator: opcodes, command
// encoding, FSM states and per-command frame/reply lengths.
package sys_cmd_pkg;

    localparam logic [7:0] OpRegWr  = 8'hAA;
    localparam logic [7:0] OpRegRd  = 8'hBB;
    localparam logic [7:0] OpAluOp  = 8'hCC;
    localparam logic [7:0] OpAluNop = 8'hDD;

    typedef enum logic [1:0] {
        CmdRegWr  = 2'd0,
        CmdRegRd  = 2'd1,
        CmdAluOp  = 2'd2,
        CmdAluNop = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitRsp0,
        StWaitRsp1,
        StResp
    } state_e;

    localparam logic [2:0] FrameLenRegWr  = 3'd3;
    localparam logic [2:0] FrameLenRegRd  = 3'd2;
    localparam logic [2:0] FrameLenAluOp  = 3'd4;
    localparam logic [2:0] FrameLenAluNop = 3'd2;

    localparam logic [1:0] RspLenRegWr  = 2'd0;
    localparam logic [1:0] RspLenRegRd  = 2'd1;
    localparam logic [1:0] RspLenAluOp  = 2'd2;
    localparam logic [1:0] RspLenAluNop = 2'd2;

    function automatic logic [2:0] frame_len(cmd_type_e t);
        unique case (t)
            CmdRegWr:  frame_len = FrameLenRegWr;
            CmdRegRd:  frame_len = FrameLenRegRd;
            CmdAluOp:  frame_len = FrameLenAluOp;
            CmdAluNop: frame_len = FrameLenAluNop;
        endcase
    endfunction

    function automatic logic [1:0] rsp_len(cmd_type_e t);
        unique case (t)
            CmdRegWr:  rsp_len = RspLenRegWr;
            CmdRegRd:  rsp_len = RspLenRegRd;
            CmdAluOp:  rsp_len = RspLenAluOp;
            CmdAluNop: rsp_len = RspLenAluNop;
        endcase
    endfunction

endpackage

// File: rtl/sys_cmd_master_if.sv
// Command request, UART byte and reply signals of the command initiator.
interface sys_cmd_master_if #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned ALU_FUN_WIDTH = 4,
    parameter int unsigned ALU_OUT_WIDTH = 16
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_type;
    logic [ADDRESS_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0]    cmd_wdata;
    logic [DATA_WIDTH-1:0]    cmd_op_a;
    logic [DATA_WIDTH-1:0]    cmd_op_b;
    logic [ALU_FUN_WIDTH-1:0] cmd_fun;
    logic [DATA_WIDTH-1:0]    tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic [DATA_WIDTH-1:0]    rx_data;
    logic                     rx_valid;
    logic [ALU_OUT_WIDTH-1:0] rsp_data;
    logic                     rsp_valid;
    logic                     rsp_err;

    modport master (
        input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_fun,
        output cmd_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rsp_data, rsp_valid, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_fun,
        input  cmd_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rsp_data, rsp_valid, rsp_err
    );

endinterface

// File: rtl/sys_cmd_timeout.sv
// Inter-byte reply timeout counter: clears on demand, counts while enabled and
// flags expiry when it reaches TIMEOUT_CYCLES-1.
module sys_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TO_WIDTH       = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [TO_WIDTH-1:0] Limit = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TO_WIDTH-1:0] count_q;

    assign expired = (count_q == Limit);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !expired) begin
            count_q <= count_q + TO_WIDTH'(1);
        end
    end

endmodule

// File: rtl/sys_cmd_master.sv
// Host-side initiator: serialises one command into a UART byte frame, then
// collects the 0/1/2-byte reply (LSB first) or reports a timeout.
module sys_cmd_master
    import sys_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDRESS_WIDTH  = 4,
    parameter int unsigned ALU_FUN_WIDTH  = 4,
    parameter int unsigned ALU_OUT_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TO_WIDTH       = 16
) (
    input logic             CLK,
    input logic             RST,
    sys_cmd_master_if.master bus
);
    state_e                   state_q, state_d;
    logic [2:0]               idx_q, idx_d;
    cmd_type_e                type_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q, op_a_q, op_b_q;
    logic [ALU_FUN_WIDTH-1:0] fun_q;
    logic [DATA_WIDTH-1:0]    lo_q, hi_q;
    logic                     err_q;
    logic [DATA_WIDTH-1:0]    tx_byte;
    logic                     accept, waiting, rx_take, to_expired;

    assign accept  = (state_q == StIdle) && bus.cmd_valid;
    assign waiting = state_q inside {StWaitRsp0, StWaitRsp1};
    assign rx_take = waiting && bus.rx_valid;

    // Held clear outside the wait states, so each wait state starts from zero.
    sys_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_WIDTH      (TO_WIDTH)
    ) u_timeout (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (!waiting || rx_take),
        .en     (waiting),
        .expired(to_expired)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    state_d = StSend;
                    idx_d   = '0;
                end
            end
            StSend: begin
                if (bus.tx_ready) begin
                    if (idx_q == frame_len(type_q) - 3'd1) begin
                        idx_d   = '0;
                        state_d = (rsp_len(type_q) == 2'd0) ? StResp : StWaitRsp0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StWaitRsp0: begin
                if (bus.rx_valid) begin
                    state_d = (rsp_len(type_q) == 2'd1) ? StResp : StWaitRsp1;
                end else if (to_expired) begin
                    state_d = StResp;
                end
            end
            StWaitRsp1: begin
                if (bus.rx_valid || to_expired) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            type_q  <= CmdRegWr;
            addr_q  <= '0;
            wdata_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            fun_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                type_q  <= cmd_type_e'(bus.cmd_type);
                addr_q  <= bus.cmd_addr;
                wdata_q <= bus.cmd_wdata;
                op_a_q  <= bus.cmd_op_a;
                op_b_q  <= bus.cmd_op_b;
                fun_q   <= bus.cmd_fun;
                lo_q    <= '0;
                hi_q    <= '0;
                err_q   <= 1'b0;
            end
            if (state_q == StWaitRsp0 && bus.rx_valid) lo_q <= bus.rx_data;
            if (state_q == StWaitRsp1 && bus.rx_valid) hi_q <= bus.rx_data;
            // A byte arriving on the expiry cycle takes priority over the error.
            if (waiting && to_expired && !bus.rx_valid) err_q <= 1'b1;
        end
    end

    always_comb begin
        tx_byte = '0;
        unique case (type_q)
            CmdRegWr: begin
                case (idx_q)
                    3'd0:    tx_byte = DATA_WIDTH'(OpRegWr);
                    3'd1:    tx_byte = DATA_WIDTH'(addr_q);
                    default: tx_byte = wdata_q;
                endcase
            end
            CmdRegRd: begin
                case (idx_q)
                    3'd0:    tx_byte = DATA_WIDTH'(OpRegRd);
                    default: tx_byte = DATA_WIDTH'(addr_q);
                endcase
            end
            CmdAluOp: begin
                case (idx_q)
                    3'd0:    tx_byte = DATA_WIDTH'(OpAluOp);
                    3'd1:    tx_byte = op_a_q;
                    3'd2:    tx_byte = op_b_q;
                    default: tx_byte = DATA_WIDTH'(fun_q);
                endcase
            end
            CmdAluNop: begin
                case (idx_q)
                    3'd0:    tx_byte = DATA_WIDTH'(OpAluNop);
                    default: tx_byte = DATA_WIDTH'(fun_q);
                endcase
            end
        endcase
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.tx_valid  = (state_q == StSend);
    assign bus.tx_data   = (state_q == StSend) ? tx_byte : '0;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_err   = (state_q == StResp) && err_q;
    assign bus.rsp_data  = ((state_q == StResp) && !err_q) ? ALU_OUT_WIDTH'({hi_q, lo_q}) : '0;

endmodule

// File: tb/tb_sys_cmd_master.sv
// Self-checking bench for sys_cmd_master: vector table plus hand-written
// back-pressure, timeout and reset-abort sequences, with a tx/rsp scoreboard.
module tb_sys_cmd_master;
    import sys_cmd_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    sys_cmd_master_if #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .ALU_FUN_WIDTH(4), .ALU_OUT_WIDTH(16)
    ) bus ();

    sys_cmd_master #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .ALU_FUN_WIDTH(4), .ALU_OUT_WIDTH(16),
        .TIMEOUT_CYCLES(16), .TO_WIDTH(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    typedef struct packed {
        logic [1:0]      ctype;
        logic [3:0]      addr;
        logic [7:0]      wdata;
        logic [7:0]      op_a;
        logic [7:0]      op_b;
        logic [3:0]      fun;
        logic [2:0]      ntx;
        logic [3:0][7:0] tx;
        logic [1:0]      nrx;
        logic [1:0][7:0] rx;
        logic [15:0]     rsp;
        logic            err;
    } vec_t;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } rsp_t;

    logic [7:0]  tx_q[$];
    rsp_t        rsp_q[$];
    int unsigned acc_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] t, input logic [3:0] a, input logic [7:0] wd,
                                input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f,
                                input logic [2:0] ntx, input logic [7:0] t0, input logic [7:0] t1,
                                input logic [7:0] t2, input logic [7:0] t3, input logic [1:0] nrx,
                                input logic [7:0] r0, input logic [7:0] r1,
                                input logic [15:0] rsp, input logic err);
        vec_t v;
        v.ctype = t;   v.addr = a;  v.wdata = wd; v.op_a = oa; v.op_b = ob; v.fun = f;
        v.ntx = ntx;   v.tx[0] = t0; v.tx[1] = t1; v.tx[2] = t2; v.tx[3] = t3;
        v.nrx = nrx;   v.rx[0] = r0; v.rx[1] = r1;
        v.rsp = rsp;   v.err = err;
        return v;
    endfunction

    // Scoreboard: every tx transfer and every reply strobe must match the queues.
    always @(negedge CLK) begin
        if (RST && bus.tx_valid && bus.tx_ready) begin
            if (tx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected: got byte %0h, expected no transfer", bus.tx_data);
            end else begin
                logic [7:0] exp_b;
                exp_b = tx_q.pop_front();
                check("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_b});
            end
        end
        if (RST && bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got data %0h err %0b, expected no reply",
                         bus.rsp_data, bus.rsp_err);
            end else begin
                rsp_t exp_r;
                exp_r = rsp_q.pop_front();
                check("rsp_data", {16'd0, bus.rsp_data}, {16'd0, exp_r.data});
                check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_r.err});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
        check({tag, "_tx_valid"},  {31'd0, bus.tx_valid},  32'd0);
        check({tag, "_tx_data"},   {24'd0, bus.tx_data},   32'd0);
        check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_rsp_err"},   {31'd0, bus.rsp_err},   32'd0);
        check({tag, "_rsp_data"},  {16'd0, bus.rsp_data},  32'd0);
    endtask

    task automatic send_cmd(input vec_t v);
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        check("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = v.ctype;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_op_a  = v.op_a;
        bus.cmd_op_b  = v.op_b;
        bus.cmd_fun   = v.fun;
        for (int i = 0; i < int'(v.ntx); i++) tx_q.push_back(v.tx[i]);
        rsp_q.push_back('{data: v.rsp, err: v.err});
        acc_cyc = cyc;
        @(posedge CLK); #1;
        // Scramble the request so only the captured copy can produce the frame.
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'($urandom);
        bus.cmd_addr  = 4'($urandom);
        bus.cmd_wdata = 8'($urandom);
        bus.cmd_op_a  = 8'($urandom);
        bus.cmd_op_b  = 8'($urandom);
        bus.cmd_fun   = 4'($urandom);
        check("cmd_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
    endtask

    task automatic wait_tx_done();
        int n = 0;
        while (tx_q.size() != 0 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check("tx_drained", tx_q.size(), 32'd0);
        tx_q.delete();
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge CLK); #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic wait_rsp_done();
        int n = 0;
        while (rsp_q.size() != 0 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check("rsp_seen", rsp_q.size(), 32'd0);
        rsp_q.delete();
        check("cmd_ready_after_resp", {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   n;
        vecs[0] = mk(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0,
                     3'd3, 8'hAA, 8'h05, 8'h3C, 8'h00, 2'd0, 8'h00, 8'h00, 16'h0000, 1'b0);
        vecs[1] = mk(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0,
                     3'd2, 8'hBB, 8'h02, 8'h00, 8'h00, 2'd1, 8'h81, 8'h00, 16'h0081, 1'b0);
        vecs[2] = mk(2'd2, 4'h0, 8'h00, 8'h0A, 8'h14, 4'h0,
                     3'd4, 8'hCC, 8'h0A, 8'h14, 8'h00, 2'd2, 8'h1E, 8'h00, 16'h001E, 1'b0);
        vecs[3] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hF,
                     3'd2, 8'hDD, 8'h0F, 8'h00, 8'h00, 2'd2, 8'h34, 8'h12, 16'h1234, 1'b0);
        vecs[4] = mk(2'd0, 4'hF, 8'hFF, 8'h00, 8'h00, 4'h0,
                     3'd3, 8'hAA, 8'h0F, 8'hFF, 8'h00, 2'd0, 8'h00, 8'h00, 16'h0000, 1'b0);
        vecs[5] = mk(2'd2, 4'h0, 8'h00, 8'hFF, 8'h01, 4'h9,
                     3'd4, 8'hCC, 8'hFF, 8'h01, 8'h09, 2'd2, 8'hCD, 8'hAB, 16'hABCD, 1'b0);

        bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_addr = 4'h0; bus.cmd_wdata = 8'h00;
        bus.cmd_op_a = 8'h00; bus.cmd_op_b = 8'h00; bus.cmd_fun = 4'h0;
        bus.tx_ready = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;

        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST = 1'b1;
        @(posedge CLK); #1;

        // Table-driven commands with tx_ready held high and prompt replies.
        for (int i = 0; i < 6; i++) begin
            send_cmd(vecs[i]);
            wait_tx_done();
            for (int j = 0; j < int'(vecs[i].nrx); j++) send_rx(vecs[i].rx[j]);
            wait_rsp_done();
            // Acceptance cycle to cmd_ready: 3 bytes + 2 cycles.
            if (vecs[i].ctype == 2'd0) check("regwr_latency", cyc - acc_cyc, 32'd5);
        end

        // Back-pressure on ALU_NOP fun=2.
        begin
            logic [4:0]      rdy;
            logic [4:0][7:0] exp_d;
            rdy = 5'b10100;
            exp_d[0] = 8'hDD; exp_d[1] = 8'hDD; exp_d[2] = 8'hDD;
            exp_d[3] = 8'h02; exp_d[4] = 8'h02;
            bus.tx_ready = 1'b0;
            send_cmd(mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2,
                        3'd2, 8'hDD, 8'h02, 8'h00, 8'h00, 2'd2, 8'h78, 8'h56, 16'h5678, 1'b0));
            for (int i = 0; i < 5; i++) begin
                bus.tx_ready = rdy[i];
                check("bp_tx_valid", {31'd0, bus.tx_valid}, 32'd1);
                check("bp_tx_data", {24'd0, bus.tx_data}, {24'd0, exp_d[i]});
                @(posedge CLK); #1;
            end
            bus.tx_ready = 1'b1;
            check("bp_tx_count", tx_q.size(), 32'd0);
            check("bp_tx_idle", {31'd0, bus.tx_valid}, 32'd0);
            tx_q.delete();
            send_rx(8'h78);
            send_rx(8'h56);
            wait_rsp_done();
        end

        // Timeout: REG_RD with no reply.
        send_cmd(mk(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0,
                    3'd2, 8'hBB, 8'h02, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 16'h0000, 1'b1));
        wait_tx_done();
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check("timeout_latency", n, 32'd16);
        wait_rsp_done();

        // Stray rx byte while idle, then reset in the middle of an ALU_OP frame.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h99;
        @(posedge CLK); #1;
        bus.rx_valid = 1'b0;
        check("stray_idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1; bus.cmd_type = 2'd2; bus.cmd_op_a = 8'h0A;
        bus.cmd_op_b = 8'h14; bus.cmd_fun = 4'h3;
        tx_q.push_back(8'hCC);
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        @(posedge CLK); #1;
        bus.tx_ready = 1'b0;
        check("abort_tx_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("abort_tx_data", {24'd0, bus.tx_data}, 32'h0A);
        RST = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge CLK); #1;
        RST = 1'b1;
        bus.tx_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("abort_no_reply", rsp_q.size() + tx_q.size(), 32'd0);

        v = mk(2'd1, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0,
               3'd2, 8'hBB, 8'h07, 8'h00, 8'h00, 2'd1, 8'h5A, 8'h00, 16'h005A, 1'b0);
        send_cmd(v);
        wait_tx_done();
        send_rx(8'h5A);
        wait_rsp_done();

        repeat (3) @(posedge CLK);
        #1;
        check("final_queues", tx_q.size() + rsp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
